// File: rtl/xor_ctrl_pkg.sv
// Shared types and defaults for the XOR decrypt controller.
package xor_ctrl_pkg;

   localparam int DEF_WORD_W  = 8;
   localparam int DEF_MSG_LEN = 8;
   localparam int DEF_KEY_LEN = 3;

   typedef enum logic [2:0] {
      LOAD_MSG,
      LOAD_KEY,
      READY,
      RUN,
      DONE
   } state_t;

   // Width of a counter or address that indexes 0..limit-1, never less than 1 bit.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/xor_byte_buffer.sv
// Small byte store: synchronous write, combinational read.
module xor_byte_buffer
   import xor_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_MSG_LEN,
   parameter int WIDTH = DEF_WORD_W,
   parameter int AW    = cnt_width(DEPTH)
) (
   input  logic             i_clock,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Capture one byte per write strobe; contents are never cleared.
   always_ff @(posedge i_clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/xor_decrypt_ctrl.sv
// Loads a message and a repeating key byte-by-byte, then streams msg XOR key.
module xor_decrypt_ctrl
   import xor_ctrl_pkg::*;
#(
   parameter int WORD_W  = DEF_WORD_W,
   parameter int MSG_LEN = DEF_MSG_LEN,
   parameter int KEY_LEN = DEF_KEY_LEN
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [WORD_W-1:0] i_switches,
   input  logic              i_load,
   input  logic              i_start,
   output logic [WORD_W-1:0] o_display,
   output logic              o_out_valid,
   output logic              o_busy,
   output logic              o_done
);

   localparam int MW = cnt_width(MSG_LEN);
   localparam int KW = cnt_width(KEY_LEN);
   localparam logic [MW-1:0] MSG_LAST = MW'(MSG_LEN - 1);
   localparam logic [KW-1:0] KEY_LAST = KW'(KEY_LEN - 1);

   state_t            r_state, w_state_next;
   logic [MW-1:0]     r_msg_cnt, w_msg_cnt_next;
   logic [KW-1:0]     r_key_cnt, w_key_cnt_next;
   logic [MW-1:0]     r_i, w_i_next;
   logic [KW-1:0]     r_k, w_k_next;
   logic [WORD_W-1:0] r_display;
   logic              r_out_valid, r_busy, r_done;

   logic              w_msg_we, w_key_we, w_emit;
   logic [MW-1:0]     w_msg_waddr;
   logic [WORD_W-1:0] w_msg_byte, w_key_byte;

   // Reset overrides everything, including a load in the same cycle.
   xor_byte_buffer #(.DEPTH(MSG_LEN), .WIDTH(WORD_W), .AW(MW)) u_msg_buf (
      .i_clock (i_clock),
      .i_we    (w_msg_we && !i_reset),
      .i_waddr (w_msg_waddr),
      .i_wdata (i_switches),
      .i_raddr (r_i),
      .o_rdata (w_msg_byte)
   );

   xor_byte_buffer #(.DEPTH(KEY_LEN), .WIDTH(WORD_W), .AW(KW)) u_key_buf (
      .i_clock (i_clock),
      .i_we    (w_key_we && !i_reset),
      .i_waddr (r_key_cnt),
      .i_wdata (i_switches),
      .i_raddr (r_k),
      .o_rdata (w_key_byte)
   );

   // Next-state, counter and buffer-write decisions.
   always_comb begin
      w_state_next   = r_state;
      w_msg_cnt_next = r_msg_cnt;
      w_key_cnt_next = r_key_cnt;
      w_i_next       = r_i;
      w_k_next       = r_k;
      w_msg_we       = 1'b0;
      w_key_we       = 1'b0;
      w_msg_waddr    = r_msg_cnt;
      w_emit         = 1'b0;
      case (r_state)
         LOAD_MSG: begin
            if (i_load) begin
               w_msg_we = 1'b1;
               if (r_msg_cnt == MSG_LAST) begin
                  w_msg_cnt_next = '0;
                  w_state_next   = LOAD_KEY;
               end else begin
                  w_msg_cnt_next = r_msg_cnt + MW'(1);
               end
            end
         end
         LOAD_KEY: begin
            if (i_load) begin
               w_key_we = 1'b1;
               if (r_key_cnt == KEY_LAST) begin
                  w_key_cnt_next = '0;
                  w_state_next   = READY;
               end else begin
                  w_key_cnt_next = r_key_cnt + KW'(1);
               end
            end
         end
         READY: begin
            // start has priority; a simultaneous load is dropped
            if (i_start) begin
               w_state_next = RUN;
               w_i_next     = '0;
               w_k_next     = '0;
            end
         end
         RUN: begin
            w_emit   = 1'b1;
            w_k_next = (r_k == KEY_LAST) ? '0 : r_k + KW'(1);
            if (r_i == MSG_LAST) begin
               w_state_next = DONE;
               w_i_next     = '0;
               w_k_next     = '0;
            end else begin
               w_i_next = r_i + MW'(1);
            end
         end
         DONE: begin
            // load has priority: it restarts message entry with this byte in slot 0
            if (i_load) begin
               w_msg_we    = 1'b1;
               w_msg_waddr = '0;
               if (MSG_LAST == '0) begin
                  w_msg_cnt_next = '0;
                  w_state_next   = LOAD_KEY;
               end else begin
                  w_msg_cnt_next = MW'(1);
                  w_state_next   = LOAD_MSG;
               end
            end else if (i_start) begin
               w_state_next = RUN;
               w_i_next     = '0;
               w_k_next     = '0;
            end
         end
         default: w_state_next = LOAD_MSG;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= LOAD_MSG;
         r_msg_cnt   <= '0;
         r_key_cnt   <= '0;
         r_i         <= '0;
         r_k         <= '0;
         r_display   <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_msg_cnt   <= w_msg_cnt_next;
         r_key_cnt   <= w_key_cnt_next;
         r_i         <= w_i_next;
         r_k         <= w_k_next;
         if (w_emit) begin
            r_display <= w_msg_byte ^ w_key_byte;
         end
         r_out_valid <= w_emit;
         r_busy      <= w_emit;
         // done drops on the same edge that load/start leaves DONE
         r_done      <= (r_state == DONE) && (w_state_next == DONE);
      end
   end

   assign o_display   = r_display;
   assign o_out_valid = r_out_valid;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule

// File: tb/tb_xor_decrypt_ctrl.sv
// Bench for xor_decrypt_ctrl: two instances (KEY_LEN 3 and 1) share stimulus;
// each has a queue-based reference model checked every cycle.
module tb_xor_decrypt_ctrl;

   localparam int W  = 8;
   localparam int ML = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld  = 1'b0;
   logic       st  = 1'b0;
   logic [7:0] sw  = 8'h00;

   int checks = 0;
   int errors = 0;

   logic [7:0] cap0 [256];
   logic [7:0] cap1 [256];
   int         tot0 = 0;
   int         tot1 = 0;

   logic [7:0] msg_lit [ML] = '{8'h01, 8'h14, 8'h14, 8'h01, 8'h03, 8'h0B, 8'h05, 8'h12};
   logic [7:0] key_lit [3]  = '{8'h15, 8'h0A, 8'h19};
   logic [7:0] exp_k3  [ML] = '{8'h14, 8'h1E, 8'h0D, 8'h14, 8'h09, 8'h12, 8'h10, 8'h18};
   logic [7:0] exp_k1  [ML] = '{8'h14, 8'h01, 8'h01, 8'h14, 8'h16, 8'h1E, 8'h10, 8'h07};

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int KL = (gi == 0) ? 3 : 1;

      logic [7:0] disp;
      logic       ov, busy, done;

      xor_decrypt_ctrl #(.WORD_W(W), .MSG_LEN(ML), .KEY_LEN(KL)) u_dut (
         .i_clock     (clk),
         .i_reset     (rst),
         .i_switches  (sw),
         .i_load      (ld),
         .i_start     (st),
         .o_display   (disp),
         .o_out_valid (ov),
         .o_busy      (busy),
         .o_done      (done)
      );

      // Reference model: bytes loaded so far, a queue of pending output bytes.
      logic [7:0] m_msg [ML];
      logic [7:0] m_key [KL];
      logic [7:0] q [$];
      int         nloaded   = 0;
      bit         in_done   = 1'b0;
      bit         live      = 1'b0;
      logic [7:0] exp_disp  = 8'h00;
      bit         exp_valid = 1'b0;
      bit         exp_busy  = 1'b0;
      bit         exp_done  = 1'b0;

      always @(posedge clk) begin
         if (rst) begin
            nloaded = 0;
            q.delete();
            in_done  = 1'b0;
            exp_disp = 8'h00;
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            live      = 1'b1;
         end else begin
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            if (q.size() > 0) begin
               exp_disp  = q.pop_front();
               exp_valid = 1'b1;
               exp_busy  = 1'b1;
               if (q.size() == 0) in_done = 1'b1;
            end else if (in_done) begin
               if (ld) begin
                  m_msg[0] = sw;
                  nloaded  = 1;
                  in_done  = 1'b0;
               end else if (st) begin
                  for (int j = 0; j < ML; j++) q.push_back(m_msg[j] ^ m_key[j % KL]);
                  in_done = 1'b0;
               end else begin
                  exp_done = 1'b1;
               end
            end else if (nloaded < ML + KL) begin
               if (ld) begin
                  if (nloaded < ML) m_msg[nloaded] = sw;
                  else              m_key[nloaded - ML] = sw;
                  nloaded++;
               end
            end else if (st) begin
               for (int j = 0; j < ML; j++) q.push_back(m_msg[j] ^ m_key[j % KL]);
            end
         end
      end
   end

   task automatic cmp(input int kl, input logic [7:0] d, input logic [7:0] ed,
                      input logic v, input logic ev, input logic b, input logic eb,
                      input logic dn, input logic edn);
      checks++;
      if (d !== ed || v !== ev || b !== eb || dn !== edn) begin
         errors++;
         $display("FAIL model_k%0d t=%0t got disp=%02h valid=%b busy=%b done=%b, expected disp=%02h valid=%b busy=%b done=%b",
                  kl, $time, d, v, b, dn, ed, ev, eb, edn);
      end
   endtask

   // Per-cycle comparison against the models, plus capture of emitted bytes.
   always @(negedge clk) begin
      if (g_dut[0].live) begin
         cmp(3, g_dut[0].disp, g_dut[0].exp_disp, g_dut[0].ov, g_dut[0].exp_valid,
             g_dut[0].busy, g_dut[0].exp_busy, g_dut[0].done, g_dut[0].exp_done);
         if (g_dut[0].ov === 1'b1) begin
            cap0[tot0 % 256] = g_dut[0].disp;
            tot0++;
         end
      end
      if (g_dut[1].live) begin
         cmp(1, g_dut[1].disp, g_dut[1].exp_disp, g_dut[1].ov, g_dut[1].exp_valid,
             g_dut[1].busy, g_dut[1].exp_busy, g_dut[1].done, g_dut[1].exp_done);
         if (g_dut[1].ov === 1'b1) begin
            cap1[tot1 % 256] = g_dut[1].disp;
            tot1++;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end else begin
         $display("check %s = %0h ok", name, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_byte(input logic [7:0] b);
      sw = b;
      ld = 1'b1;
      step();
      ld = 1'b0;
   endtask

   task automatic pulse_start();
      st = 1'b1;
      step();
      st = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic load_literal();
      for (int j = 0; j < ML; j++) load_byte(msg_lit[j]);
      for (int j = 0; j < 3; j++) load_byte(key_lit[j]);
   endtask

   task automatic wait_done();
      int n = 0;
      while (g_dut[0].done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (g_dut[0].done !== 1'b1) begin
         errors++;
         $display("FAIL wait_done got=timeout expected=done within 40 cycles");
      end
   endtask

   task automatic check_stream(input string tag, input int b0, input int b1);
      for (int j = 0; j < ML; j++) begin
         chk($sformatf("%s_k3_byte%0d", tag, j), {24'd0, cap0[(b0 + j) % 256]}, {24'd0, exp_k3[j]});
         chk($sformatf("%s_k1_byte%0d", tag, j), {24'd0, cap1[(b1 + j) % 256]}, {24'd0, exp_k1[j]});
      end
   endtask

   initial begin
      int b0, b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("reset_disp", {24'd0, g_dut[0].disp}, 32'h0);
      chk("reset_valid", {31'd0, g_dut[0].ov}, 32'h0);
      chk("reset_done", {31'd0, g_dut[0].done}, 32'h0);

      // Start strobe after three message loads is ignored; fourth load lands in msg[3].
      for (int j = 0; j < 3; j++) load_byte(msg_lit[j]);
      pulse_start();
      chk("start_in_load_valid", {31'd0, g_dut[0].ov}, 32'h0);
      for (int j = 3; j < ML; j++) load_byte(msg_lit[j]);
      for (int j = 0; j < 3; j++) load_byte(key_lit[j]);
      b0 = tot0; b1 = tot1;
      pulse_start();
      wait_done();
      check_stream("first_run", b0, b1);

      // Replay from DONE with unchanged buffers.
      b0 = tot0; b1 = tot1;
      pulse_start();
      wait_done();
      check_stream("replay", b0, b1);

      // Reset while the 4th byte is on the output.
      b0 = tot0;
      pulse_start();
      repeat (4) step();
      chk("fourth_valid_before_reset", {31'd0, g_dut[0].ov}, 32'h1);
      do_reset();
      chk("midrun_reset_valid", {31'd0, g_dut[0].ov}, 32'h0);
      chk("midrun_reset_disp", {24'd0, g_dut[0].disp}, 32'h0);
      repeat (3) step();
      chk("midrun_reset_count", tot0 - b0, 32'd4);
      for (int j = 0; j < ML + 3; j++) load_byte(8'($urandom));
      pulse_start();
      wait_done();

      // Structured random runs with ignored start strobes and load+start in READY.
      for (int it = 0; it < 6; it++) begin
         if (it % 2 == 0) do_reset();
         for (int j = 0; j < ML; j++) begin
            repeat ($urandom_range(0, 2)) begin
               st = ($urandom % 3 == 0);
               step();
               st = 1'b0;
            end
            load_byte(8'($urandom));
         end
         for (int j = 0; j < 3; j++) load_byte(8'($urandom));
         step();
         sw = 8'($urandom);
         ld = $urandom % 2;
         pulse_start();
         ld = 1'b0;
         repeat (ML + 2) step();
      end

      // Unconstrained random traffic.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom % 100 == 0);
         ld  = ($urandom % 3 == 0);
         st  = ($urandom % 4 == 0);
         sw  = 8'($urandom);
         step();
      end
      rst = 1'b0; ld = 1'b0; st = 1'b0;

      // load and start together in DONE: load wins.
      do_reset();
      load_literal();
      pulse_start();
      wait_done();
      sw = 8'h41;
      ld = 1'b1;
      st = 1'b1;
      step();
      ld = 1'b0;
      st = 1'b0;
      chk("load_start_done_k3_done", {31'd0, g_dut[0].done}, 32'h0);
      chk("load_start_done_k3_valid", {31'd0, g_dut[0].ov}, 32'h0);
      chk("load_start_done_k1_done", {31'd0, g_dut[1].done}, 32'h0);
      repeat (3) step();
      for (int j = 1; j < ML; j++) load_byte(msg_lit[j]);
      for (int j = 0; j < 3; j++) load_byte(key_lit[j]);
      b0 = tot0; b1 = tot1;
      pulse_start();
      wait_done();
      chk("msg0_0x41_k3", {24'd0, cap0[b0 % 256]}, 32'h54);
      chk("msg0_0x41_k1", {24'd0, cap1[b1 % 256]}, 32'h54);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_decrypt_ctrl.md
XOR_DECRYPT_CTRL -- requirements
Module: xor_decrypt_ctrl

Interface
REQ-001 Parameter WORD_W, default 8, width of message, key and output bytes.
REQ-002 Parameter MSG_LEN, default 8, number of message bytes per run.
REQ-003 Parameter KEY_LEN, default 3, number of key bytes, range 1..MSG_LEN.
REQ-004 Clocking is decided: one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 switches  in  WORD_W  byte captured on load.
REQ-008 load  in  1  one-cycle strobe; captures switches into the next buffer slot.
REQ-009 start  in  1  one-cycle strobe; begins the decrypt stream.
REQ-010 display  out  WORD_W  decrypted byte; registered.
REQ-011 out_valid  out  1  high while display carries a new decrypted byte.
REQ-012 busy  out  1  high in RUN.
REQ-013 done  out  1  high in DONE.

Function
REQ-014 States SHALL be LOAD_MSG, LOAD_KEY, READY, RUN and DONE.
REQ-015 In LOAD_MSG, load SHALL write switches to msg[msg_cnt] and increment msg_cnt.
- On the load with msg_cnt = MSG_LEN-1: msg_cnt wraps to 0 and the state goes to LOAD_KEY.
REQ-016 In LOAD_KEY, load SHALL write switches to key[key_cnt] and increment key_cnt.
- On the load with key_cnt = KEY_LEN-1: key_cnt wraps to 0 and the state goes to READY.
REQ-017 In LOAD_MSG, LOAD_KEY and RUN, start SHALL be ignored.
REQ-018 In READY and RUN, load SHALL be ignored and the buffers SHALL be unchanged.
REQ-019 start in READY SHALL enter RUN with byte index i = 0 and key index k = 0.
REQ-020 In RUN, each cycle SHALL register display = msg[i] XOR key[k] and set out_valid = 1.
- i increments by 1.
- k increments by 1 and wraps from KEY_LEN-1 to 0; no divider or modulo operator.
REQ-021 Timing: start sampled at edge N gives out_valid = 1 after edges N+1 .. N+MSG_LEN, exactly MSG_LEN consecutive cycles.
REQ-022 After edge N+MSG_LEN the state SHALL be DONE.
- done = 1 and busy = 0 from edge N+MSG_LEN+1 onward.
- out_valid = 0 and display holds the last byte.
REQ-023 start in DONE SHALL replay RUN from i = 0, k = 0 using the unchanged buffers.
REQ-024 load in DONE SHALL go to LOAD_MSG and clear done.
- It writes switches to msg[0] and sets msg_cnt = 1.
REQ-025 If load and start are both high in DONE, load SHALL win.
REQ-026 If load and start are both high in READY, start SHALL win and load is ignored.
REQ-027 The XOR SHALL be full WORD_W width, bitwise, with no carry or sign.
REQ-028 In every state except RUN, out_valid SHALL be 0.

Reset
REQ-029 reset SHALL override all other inputs in the same cycle.
REQ-030 reset SHALL set state LOAD_MSG, msg_cnt = 0, key_cnt = 0, i = 0, k = 0.
REQ-031 reset SHALL set display = 0, out_valid = 0, busy = 0, done = 0.
REQ-032 Buffer contents need not be cleared; they are unobservable until rewritten.
REQ-033 reset asserted mid-RUN SHALL end the stream.
- out_valid = 0 after that edge; no further bytes are emitted.

Structure
REQ-034 Package xor_ctrl_pkg SHALL hold the state enum type and the default WORD_W, MSG_LEN and KEY_LEN constants.
REQ-035 Message and key storage SHALL be two instances of one sub-module, xor_byte_buffer.
- Parameterised depth and width.
- Synchronous write, combinational read.
REQ-036 Counter widths SHALL be $clog2 of their limits, minimum 1 bit.

Verification
REQ-037 Reset, then load 01,14,14,01,03,0B,05,12 then keys 15,0A,19, then start.
- Response: display 14,1E,0D,14,09,12,10,18 on 8 consecutive out_valid cycles.
- done rises the following cycle.
REQ-038 start pulsed in LOAD_MSG after 3 loads.
- Response: no out_valid, state unchanged; the 4th load goes to msg[3].
REQ-039 In DONE, pulse start again.
- Response: the identical sequence 14,1E,0D,14,09,12,10,18 is replayed.
REQ-040 reset asserted on the 4th out_valid cycle.
- Response: out_valid = 0 and display = 00 next cycle; the next load writes msg[0].
REQ-041 KEY_LEN = 1, key 15, same message.
- Response: 14,01,01,14,16,1E,10,07.
REQ-042 load and start both high in DONE with switches = 0x41.
- Response: LOAD_MSG, done = 0, msg[0] = 0x41, no out_valid.
